bisect_searcher: RTL and testbench

//  Snaps a detected pitch value to the nearest entry in a sorted note-frequency ROM, using a binary search.

---
 rtl/bisect_searcher.sv | 181 ++++++++++++++++++
 tb/tb_bisect_searcher.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bisect_searcher.sv
// Snaps a key to the nearest entry of a sorted semitone table (entry i = 16*i + 8) by fixed-latency bisection.
// Optional statistics counters are enabled with the SEARCHER_STATS_EN macro.
module bisect_searcher #(
  parameter int WIDTH  = 12,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic [WIDTH-1:0]  search_val_in,
  output logic              resp_valid_out,
  input  logic              resp_ready_in,
  output logic [WIDTH-1:0]  closest_val_out,
  output logic [ADDR_W-1:0] closest_idx_out,
  output logic [WIDTH:0]    offset_out,
`ifdef SEARCHER_STATS_EN
  output logic [15:0]       resp_count_out,
  output logic [15:0]       clamp_count_out,
`endif
  output logic              clamped_out
);

  localparam int CNT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, PROBE0, BISECT, NEIGH, RESOLVE, RESP} state_t;

  state_t              r_state, w_nextState;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_bitMask;
  logic [ADDR_W-1:0]   r_pos;
  logic [WIDTH-1:0]    r_key, r_loVal, r_hiVal;
  logic [WIDTH-1:0]    r_romPipe [RD_LAT];
  logic                r_respValid, r_clamped;
  logic [WIDTH-1:0]    r_closestVal;
  logic [ADDR_W-1:0]   r_closestIdx;
  logic [WIDTH:0]      r_offset;

  logic                w_probing, w_probeLast, w_accept, w_respFire;
  logic [ADDR_W-1:0]   w_probeAddr;
  logic [WIDTH-1:0]    w_romData;
  logic [WIDTH-1:0]    w_dLo, w_dHi, w_selVal;
  logic [ADDR_W-1:0]   w_selIdx;
  logic                w_selClamp;

  function automatic logic [WIDTH-1:0] romEntry(input logic [ADDR_W-1:0] addr);
    return WIDTH'(32'(addr) * 32'd16 + 32'd8);
  endfunction

  assign w_probing   = (r_state == PROBE0) || (r_state == BISECT) || (r_state == NEIGH);
  assign w_probeLast = w_probing && (r_cnt == CNT_W'(RD_LAT));
  assign w_accept    = (r_state == IDLE) && req_valid_in && rst_n_in;
  assign w_respFire  = (r_state == RESP) && resp_ready_in;
  assign w_romData   = r_romPipe[RD_LAT-1];

  assign req_ready_out   = (r_state == IDLE) && rst_n_in;
  assign resp_valid_out  = r_respValid;
  assign closest_val_out = r_closestVal;
  assign closest_idx_out = r_closestIdx;
  assign offset_out      = r_offset;
  assign clamped_out     = r_clamped;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (req_valid_in) w_nextState = PROBE0;
      PROBE0:  if (w_probeLast) w_nextState = BISECT;
      BISECT:  if (w_probeLast && r_bitMask[0]) w_nextState = NEIGH;
      NEIGH:   if (w_probeLast) w_nextState = RESOLVE;
      RESOLVE: w_nextState = RESP;
      RESP:    if (resp_ready_in) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The address is held for the whole probe; only the value launched on its first cycle is consumed.
  always_comb begin
    w_probeAddr = '0;
    case (r_state)
      BISECT:  w_probeAddr = r_pos | r_bitMask;
      NEIGH:   w_probeAddr = (r_pos == LAST_IDX) ? r_pos : r_pos + 1'b1;
      default: w_probeAddr = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < RD_LAT; k++) r_romPipe[k] <= '0;
    end else begin
      r_romPipe[0] <= romEntry(w_probeAddr);
      for (int k = 1; k < RD_LAT; k++) r_romPipe[k] <= r_romPipe[k-1];
    end
  end

  always_comb begin
    w_dLo      = r_key - r_loVal;
    w_dHi      = r_hiVal - r_key;
    w_selIdx   = r_pos;
    w_selVal   = r_loVal;
    w_selClamp = 1'b0;
    if (r_key < r_loVal) begin
      w_selIdx   = '0;
      w_selClamp = 1'b1;
    end else if ((r_pos == LAST_IDX) && (r_key > r_loVal)) begin
      w_selClamp = 1'b1;
    end else if (w_dLo > w_dHi) begin
      w_selIdx = r_pos + 1'b1;
      w_selVal = r_hiVal;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt        <= '0;
      r_bitMask    <= '0;
      r_pos        <= '0;
      r_key        <= '0;
      r_loVal      <= '0;
      r_hiVal      <= '0;
      r_respValid  <= 1'b0;
      r_clamped    <= 1'b0;
      r_closestVal <= '0;
      r_closestIdx <= '0;
      r_offset     <= '0;
    end else begin
      if (w_probing) r_cnt <= w_probeLast ? '0 : r_cnt + 1'b1;
      else           r_cnt <= '0;
      if (w_accept) begin
        r_key     <= search_val_in;
        r_bitMask <= {1'b1, {(ADDR_W-1){1'b0}}};
      end
      if (w_probeLast && (r_state == PROBE0)) begin
        r_loVal <= w_romData;
        r_pos   <= '0;
      end
      if (w_probeLast && (r_state == BISECT)) begin
        if (w_romData <= r_key) begin
          r_pos   <= w_probeAddr;
          r_loVal <= w_romData;
        end
        r_bitMask <= r_bitMask >> 1;
      end
      if (w_probeLast && (r_state == NEIGH)) r_hiVal <= w_romData;
      if (r_state == RESOLVE) begin
        r_respValid  <= 1'b1;
        r_closestIdx <= w_selIdx;
        r_closestVal <= w_selVal;
        r_clamped    <= w_selClamp;
        r_offset     <= {1'b0, r_key} - {1'b0, w_selVal};
      end else if (w_respFire) begin
        r_respValid <= 1'b0;
      end
    end
  end

`ifdef SEARCHER_STATS_EN
  logic [15:0] r_respCount, r_clampCount;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_respCount  <= '0;
      r_clampCount <= '0;
    end else if (w_respFire) begin
      r_respCount <= r_respCount + 1'b1;
      if (r_clamped && (r_clampCount != 16'hFFFF)) r_clampCount <= r_clampCount + 1'b1;
    end
  end

  assign resp_count_out  = r_respCount;
  assign clamp_count_out = r_clampCount;
`endif

endmodule

// File: tb/tb_bisect_searcher.sv
// Directed self-checking bench for bisect_searcher against the table entry i = 16*i + 8.
module tb_bisect_searcher;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic [11:0] search_val_in = '0;
  logic        resp_valid_out;
  logic        resp_ready_in = 1'b0;
  logic [11:0] closest_val_out;
  logic [5:0]  closest_idx_out;
  logic [12:0] offset_out;
  logic        clamped_out;
`ifdef SEARCHER_STATS_EN
  logic [15:0] resp_count_out, clamp_count_out;
`endif

  int assertCount = 0;
  int failCount   = 0;

  bisect_searcher dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out), .search_val_in(search_val_in),
    .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
    .closest_val_out(closest_val_out), .closest_idx_out(closest_idx_out), .offset_out(offset_out),
`ifdef SEARCHER_STATS_EN
    .resp_count_out(resp_count_out), .clamp_count_out(clamp_count_out),
`endif
    .clamped_out(clamped_out)
  );

  always #5 clk_in = ~clk_in;

  // Issues one request and leaves the response pending; lat counts cycles from accept edge to resp_valid.
  task automatic applyStimulus(input logic [11:0] key, output int lat, output bit timedOut);
    int n = 0;
    timedOut = 1'b0;
    lat = 0;
    @(negedge clk_in);
    while (!req_ready_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (!req_ready_out) begin
      timedOut = 1'b1;
      return;
    end
    req_valid_in  = 1'b1;
    search_val_in = key;
    @(posedge clk_in);
    #1 req_valid_in = 1'b0;
    while (!resp_valid_out && lat < 100) begin
      @(posedge clk_in);
      #1 lat++;
    end
    timedOut = !resp_valid_out;
  endtask

  task automatic consume();
    @(negedge clk_in);
    resp_ready_in = 1'b1;
    @(posedge clk_in);
    #1 resp_ready_in = 1'b0;
  endtask

  task automatic checkResult(input string name, input logic [11:0] key, input logic [5:0] expIdx,
                             input logic [11:0] expVal, input logic [12:0] expOff, input logic expClamp,
                             input int expLat);
    int lat;
    bit timedOut;
    applyStimulus(key, lat, timedOut);
    assertCount++;
    if (timedOut) begin
      failCount++;
      $display("[TB] FAIL %s timeout: resp_valid never seen (key %0d)", name, key);
      return;
    end
    if (expLat > 0) begin
      assertCount++;
      if (lat !== expLat) begin
        failCount++;
        $display("[TB] FAIL %s latency: got %0d, want %0d", name, lat, expLat);
      end
    end
    assertCount++;
    if (closest_idx_out !== expIdx || closest_val_out !== expVal || offset_out !== expOff || clamped_out !== expClamp) begin
      failCount++;
      $display("[TB] FAIL %s result: got idx %0d val %0d off %h clamp %b, want idx %0d val %0d off %h clamp %b",
               name, closest_idx_out, closest_val_out, offset_out, clamped_out, expIdx, expVal, expOff, expClamp);
    end
    consume();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    assertCount++;
    if (req_ready_out !== 1'b0 || resp_valid_out !== 1'b0 || closest_val_out !== '0 ||
        closest_idx_out !== '0 || offset_out !== '0 || clamped_out !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_state: got rdy %b vld %b val %0d idx %0d off %h clamp %b, want all 0",
               req_ready_out, resp_valid_out, closest_val_out, closest_idx_out, offset_out, clamped_out);
    end
    rst_n_in = 1'b1;
    @(negedge clk_in);
    assertCount++;
    if (req_ready_out !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL ready_after_reset: got %b, want 1", req_ready_out);
    end
  endtask

  task automatic test_exact();
    checkResult("exact_40", 12'd40, 6'd2, 12'd40, 13'd0, 1'b0, 25);
    checkResult("exact_first", 12'd8, 6'd0, 12'd8, 13'd0, 1'b0, 25);
    checkResult("exact_last", 12'd1016, 6'd63, 12'd1016, 13'd0, 1'b0, 25);
  endtask

  task automatic test_nearest();
    checkResult("tie_48", 12'd48, 6'd2, 12'd40, 13'd8, 1'b0, 25);
    checkResult("upper_50", 12'd50, 6'd3, 12'd56, 13'h1FFA, 1'b0, 25);
    checkResult("lower_505", 12'd505, 6'd31, 12'd504, 13'd1, 1'b0, 25);
  endtask

  task automatic test_clamp();
    checkResult("clamp_low", 12'd0, 6'd0, 12'd8, 13'h1FF8, 1'b1, 25);
    checkResult("clamp_high", 12'd4000, 6'd63, 12'd1016, 13'd2984, 1'b1, 25);
  endtask

  task automatic test_backpressure();
    int lat;
    bit timedOut;
    bit unstable = 1'b0;
    applyStimulus(12'd50, lat, timedOut);
    assertCount++;
    if (timedOut) begin
      failCount++;
      $display("[TB] FAIL backpressure timeout: resp_valid never seen");
      return;
    end
    repeat (10) begin
      @(negedge clk_in);
      if (resp_valid_out !== 1'b1 || req_ready_out !== 1'b0 || closest_idx_out !== 6'd3 ||
          closest_val_out !== 12'd56 || offset_out !== 13'h1FFA || clamped_out !== 1'b0)
        unstable = 1'b1;
    end
    assertCount++;
    if (unstable) begin
      failCount++;
      $display("[TB] FAIL backpressure_hold: got vld %b rdy %b idx %0d val %0d, want 1 0 3 56",
               resp_valid_out, req_ready_out, closest_idx_out, closest_val_out);
    end
    @(negedge clk_in);
    resp_ready_in = 1'b1;
    assertCount++;
    if (req_ready_out !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ready_before_handshake: got %b, want 0", req_ready_out);
    end
    @(posedge clk_in);
    #1 resp_ready_in = 1'b0;
    assertCount++;
    if (resp_valid_out !== 1'b0 || req_ready_out !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL after_handshake: got vld %b rdy %b, want 0 1", resp_valid_out, req_ready_out);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk_in);
    req_valid_in  = 1'b1;
    search_val_in = 12'd50;
    @(posedge clk_in);
    #1 req_valid_in = 1'b0;
    repeat (6) @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    assertCount++;
    if (resp_valid_out !== 1'b0 || req_ready_out !== 1'b0 || closest_val_out !== '0 ||
        closest_idx_out !== '0 || offset_out !== '0 || clamped_out !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL abort_outputs: got vld %b rdy %b val %0d idx %0d off %h clamp %b, want all 0",
               resp_valid_out, req_ready_out, closest_val_out, closest_idx_out, offset_out, clamped_out);
    end
    repeat (30) @(negedge clk_in);
    assertCount++;
    if (resp_valid_out !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL abort_no_resp: got resp_valid %b, want 0", resp_valid_out);
    end
    rst_n_in = 1'b1;
    checkResult("after_abort", 12'd600, 6'd37, 12'd600, 13'd0, 1'b0, 25);
  endtask

  task automatic test_back_to_back();
    checkResult("b2b_a", 12'd1000, 6'd62, 12'd1000, 13'd0, 1'b0, 25);
    checkResult("b2b_b", 12'd20, 6'd1, 12'd24, 13'h1FFC, 1'b0, 25);
  endtask

`ifdef SEARCHER_STATS_EN
  task automatic test_stats();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    checkResult("stats_1", 12'd0, 6'd0, 12'd8, 13'h1FF8, 1'b1, 0);
    checkResult("stats_2", 12'd40, 6'd2, 12'd40, 13'd0, 1'b0, 0);
    checkResult("stats_3", 12'd4000, 6'd63, 12'd1016, 13'd2984, 1'b1, 0);
    checkResult("stats_4", 12'd48, 6'd2, 12'd40, 13'd8, 1'b0, 0);
    checkResult("stats_5", 12'd50, 6'd3, 12'd56, 13'h1FFA, 1'b0, 0);
    @(negedge clk_in);
    assertCount++;
    if (resp_count_out !== 16'd5 || clamp_count_out !== 16'd2) begin
      failCount++;
      $display("[TB] FAIL stats_counts: got resp %0d clamp %0d, want 5 2", resp_count_out, clamp_count_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_exact();
    test_nearest();
    test_clamp();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
`ifdef SEARCHER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
